seq_detect_ctrl: RTL and testbench

Programmable controller for the serial bit-pattern detector datapath. It holds the detector configuration: pattern, length and overlap mode. It sequences detection through an idle/armed state machine and counts matches. Each match is reported to a downstream consumer through a valid/ack event handshake. It sits between the serial bit source and the control/status logic, replacing hard-wired fixed-pattern detectors.

---
 rtl/seq_detect_pkg.sv | 21 ++
 rtl/seq_match_core.sv | 66 ++++++
 rtl/seq_detect_ctrl.sv | 160 ++++++++++++++++
 tb/tb_seq_detect_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_detect_pkg.sv
// Shared types and constants for the serial pattern detector controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seq_detect_pkg;

  // Controller state: detection is either disarmed or consuming bits.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ARMED = 1'b1
  } state_e;

  // Configuration values restored by reset.
  localparam int   DEF_LEN     = 1;
  localparam logic DEF_OVERLAP = 1'b1;

  // The length field must hold the value MAX_LEN itself, hence the +1.
  function automatic int len_width(input int max_len);
    return $clog2(max_len) + 1;
  endfunction

endpackage

// File: rtl/seq_match_core.sv
// Shift register, fill counter and length-masked compare for the detector.
// Latency: hit_o is combinational on the shifting cycle, match_o follows one cycle later.
// Backpressure: none; a bit is consumed whenever shift_i is high.
module seq_match_core
  import seq_detect_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = len_width(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr_i,
  input  logic               shift_i,
  input  logic               bit_i,
  input  logic [LEN_W-1:0]   len_i,
  input  logic [MAX_LEN-1:0] pattern_i,
  input  logic               overlap_i,
  output logic               hit_o,
  output logic               match_o
);

  localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(MAX_LEN);

  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W-1:0]   fill_q, fill_d, fill_inc;
  logic               match_q;

  // Bits at or above the programmed length take no part in the compare.
  always_comb begin
    mask = '0;
    for (int k = 0; k < MAX_LEN; k++) begin
      mask[k] = (k < int'(len_i));
    end
  end

  // Shift the new bit in and compare against the post-shift history in the same cycle.
  always_comb begin
    hist_d   = hist_q;
    fill_d   = fill_q;
    fill_inc = (fill_q == FILL_MAX) ? fill_q : fill_q + LEN_W'(1);
    hit_o    = 1'b0;
    if (shift_i) begin
      hist_d = {hist_q[MAX_LEN-2:0], bit_i};
      hit_o  = (fill_inc >= len_i) && ((hist_d & mask) == (pattern_i & mask));
      // Non-overlapping mode forgets the matched bits so the next match needs a fresh window.
      fill_d = (hit_o && !overlap_i) ? '0 : fill_inc;
    end
  end

  // History, fill and the registered match pulse; clear is used when detection is armed.
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      hist_q  <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
    end else begin
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      match_q <= hit_o;
    end
  end

  assign match_o = match_q;

endmodule

// File: rtl/seq_detect_ctrl.sv
// Programmable serial bit-pattern detector controller with match counter and event handshake.
// Latency: a matching bit sampled at edge N shows out/match_cnt/evt_valid after edge N.
// Backpressure: events are never stalled; a match while one is pending sets evt_ovf.
module seq_detect_ctrl
  import seq_detect_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 16,
  parameter int LEN_W   = len_width(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               start,
  input  logic               stop,
  input  logic               bit_valid,
  input  logic               i,
  output logic               out,
  output logic               evt_valid,
  input  logic               evt_ack,
  output logic               evt_ovf,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               busy,
  output logic               cfg_err
);

  state_e state_q, state_d;

  logic [MAX_LEN-1:0] pat_q;
  logic [LEN_W-1:0]   len_q;
  logic               ovl_q;
  logic               cfg_err_q;

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               evt_valid_q, evt_valid_d;
  logic               evt_ovf_q, evt_ovf_d;

  logic               arm_fire;
  logic               shift_en;
  logic               len_ok;
  logic               cfg_acc;
  logic               hit;
  logic               match;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: stop dominates start, and start is meaningless once armed.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start && !stop) state_d = ST_ARMED;
      ST_ARMED: if (stop)           state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: arming pulse, shift qualification and busy flag.
  always_comb begin
    arm_fire = (state_q == ST_IDLE) && start && !stop;
    shift_en = (state_q == ST_ARMED) && bit_valid;
    busy     = (state_q == ST_ARMED);
  end

  // A write is only safe while disarmed and with a length the compare can represent.
  always_comb begin
    len_ok  = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
    cfg_acc = cfg_we && (state_q == ST_IDLE) && len_ok;
  end

  // Configuration registers; a rejected write leaves the old config intact but flags it.
  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q     <= '0;
      len_q     <= LEN_W'(DEF_LEN);
      ovl_q     <= DEF_OVERLAP;
      cfg_err_q <= 1'b0;
    end else if (cfg_we) begin
      if (cfg_acc) begin
        pat_q     <= cfg_pattern;
        len_q     <= cfg_len;
        ovl_q     <= cfg_overlap;
        cfg_err_q <= 1'b0;
      end else begin
        cfg_err_q <= 1'b1;
      end
    end
  end

  seq_match_core #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (arm_fire),
    .shift_i   (shift_en),
    .bit_i     (i),
    .len_i     (len_q),
    .pattern_i (pat_q),
    .overlap_i (ovl_q),
    .hit_o     (hit),
    .match_o   (match)
  );

  // Counter and event state use the unregistered hit so they line up with the out pulse.
  always_comb begin
    cnt_d       = cnt_q;
    evt_valid_d = evt_valid_q;
    evt_ovf_d   = evt_ovf_q;
    if (arm_fire) begin
      cnt_d       = '0;
      evt_valid_d = 1'b0;
      evt_ovf_d   = 1'b0;
    end else begin
      if (evt_ack) begin
        evt_valid_d = 1'b0;
      end
      if (hit) begin
        if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        evt_valid_d = 1'b1;
        // An ack in the same cycle consumes the old event, so nothing is lost.
        if (evt_valid_q && !evt_ack) begin
          evt_ovf_d = 1'b1;
        end
      end
    end
  end

  // Counter and event registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      evt_valid_q <= 1'b0;
      evt_ovf_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      evt_valid_q <= evt_valid_d;
      evt_ovf_q   <= evt_ovf_d;
    end
  end

  assign out       = match;
  assign evt_valid = evt_valid_q;
  assign evt_ovf   = evt_ovf_q;
  assign match_cnt = cnt_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed bench for seq_detect_ctrl with a second narrow-counter instance for saturation.
// Inputs change 1 time unit after each rising edge; outputs are sampled at the same point.
// Every comparison is an immediate assertion that counts and reports its own failure.
module tb_seq_detect_ctrl;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               cfg_we = 1'b0;
  logic [MAX_LEN-1:0] cfg_pattern = '0;
  logic [LEN_W-1:0]   cfg_len = '0;
  logic               cfg_overlap = 1'b0;
  logic               start = 1'b0;
  logic               stop = 1'b0;
  logic               bit_valid = 1'b0;
  logic               i = 1'b0;
  logic               evt_ack = 1'b0;

  logic               out, evt_valid, evt_ovf, busy, cfg_err;
  logic [15:0]        match_cnt;
  logic               out2, evt_valid2, evt_ovf2, busy2, cfg_err2;
  logic [1:0]         match_cnt2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_detect_ctrl #(.MAX_LEN(MAX_LEN), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .start(start), .stop(stop), .bit_valid(bit_valid), .i(i),
    .out(out), .evt_valid(evt_valid), .evt_ack(evt_ack), .evt_ovf(evt_ovf),
    .match_cnt(match_cnt), .busy(busy), .cfg_err(cfg_err)
  );

  seq_detect_ctrl #(.MAX_LEN(MAX_LEN), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .start(start), .stop(stop), .bit_valid(bit_valid), .i(i),
    .out(out2), .evt_valid(evt_valid2), .evt_ack(evt_ack), .evt_ovf(evt_ovf2),
    .match_cnt(match_cnt2), .busy(busy2), .cfg_err(cfg_err2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    bit_valid = 1'b1;
    i = b;
    tick();
    bit_valid = 1'b0;
  endtask

  // bits/exp_out are listed oldest first in the MSBs of the n-bit field.
  task automatic send_seq(input string tag, input int n, input logic [15:0] bits,
                          input logic [15:0] exp_out);
    for (int k = n - 1; k >= 0; k--) begin
      send_bit(bits[k]);
      chk($sformatf("%s_out_bit%0d", tag, n - k), 32'(out), 32'(exp_out[k]));
    end
  endtask

  task automatic cfg(input logic [7:0] p, input logic [3:0] l, input logic o);
    cfg_we = 1'b1;
    cfg_pattern = p;
    cfg_len = l;
    cfg_overlap = o;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  initial begin
    // Reset, then 5 idle cycles.
    tick();
    rst = 1'b0;
    repeat (5) tick();
    chk("rst_out", 32'(out), 0);
    chk("rst_evt_valid", 32'(evt_valid), 0);
    chk("rst_evt_ovf", 32'(evt_ovf), 0);
    chk("rst_match_cnt", 32'(match_cnt), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cfg_err", 32'(cfg_err), 0);

    // Overlapping 1101: stream 1101101 matches after bits 4 and 7.
    cfg(8'b0000_1101, 4'd4, 1'b1);
    chk("t1_cfg_err", 32'(cfg_err), 0);
    pulse_start();
    chk("t1_busy", 32'(busy), 1);
    send_seq("t1", 7, 16'b1101101, 16'b0001001);
    chk("t1_cnt", 32'(match_cnt), 2);
    chk("t1_evt_valid", 32'(evt_valid), 1);
    chk("t1_evt_ovf", 32'(evt_ovf), 1);
    pulse_stop();
    chk("t1_busy_after_stop", 32'(busy), 0);
    chk("t1_cnt_held", 32'(match_cnt), 2);

    // Non-overlapping: same stream gives one match; start clears counter and events.
    cfg(8'b0000_1101, 4'd4, 1'b0);
    pulse_start();
    chk("t2_cnt_cleared", 32'(match_cnt), 0);
    chk("t2_evt_valid_cleared", 32'(evt_valid), 0);
    chk("t2_evt_ovf_cleared", 32'(evt_ovf), 0);
    send_seq("t2", 7, 16'b1101101, 16'b0001000);
    chk("t2_cnt", 32'(match_cnt), 1);
    pulse_stop();
    pulse_start();
    send_seq("t2b", 8, 16'b11011101, 16'b00010001);
    chk("t2b_cnt", 32'(match_cnt), 2);

    // All-zero pattern, config written in the same cycle as start.
    pulse_stop();
    cfg_we = 1'b1;
    cfg_pattern = 8'h00;
    cfg_len = 4'd4;
    cfg_overlap = 1'b1;
    start = 1'b1;
    tick();
    cfg_we = 1'b0;
    start = 1'b0;
    chk("t3_busy", 32'(busy), 1);
    send_seq("t3", 5, 16'b00000, 16'b00011);
    chk("t3_cnt", 32'(match_cnt), 2);

    // Event handshake: ack two cycles after a match, then ack coinciding with a match.
    pulse_stop();
    cfg(8'b0000_1101, 4'd4, 1'b1);
    pulse_start();
    send_seq("t4a", 4, 16'b1101, 16'b0001);
    chk("t4_evt_valid_set", 32'(evt_valid), 1);
    tick();
    tick();
    chk("t4_evt_valid_pending", 32'(evt_valid), 1);
    evt_ack = 1'b1;
    tick();
    evt_ack = 1'b0;
    chk("t4_evt_valid_acked", 32'(evt_valid), 0);
    chk("t4_evt_ovf_after_ack", 32'(evt_ovf), 0);
    send_seq("t4b", 3, 16'b101, 16'b001);
    chk("t4_evt_valid_second", 32'(evt_valid), 1);
    chk("t4_evt_ovf_second", 32'(evt_ovf), 0);
    send_seq("t4c", 2, 16'b10, 16'b00);
    evt_ack = 1'b1;
    send_bit(1'b1);
    evt_ack = 1'b0;
    chk("t4_ack_match_out", 32'(out), 1);
    chk("t4_ack_match_evt_valid", 32'(evt_valid), 1);
    chk("t4_ack_match_evt_ovf", 32'(evt_ovf), 0);
    chk("t4_cnt", 32'(match_cnt), 3);

    // Rejected writes: bad lengths leave the 1101/len4 config in place.
    pulse_stop();
    cfg(8'b1111_1111, 4'd0, 1'b0);
    chk("t5_len0_err", 32'(cfg_err), 1);
    cfg(8'b0000_0011, 4'd9, 1'b0);
    chk("t5_len9_err", 32'(cfg_err), 1);
    pulse_start();
    send_seq("t5a", 4, 16'b1101, 16'b0001);
    pulse_stop();
    cfg(8'b0000_1101, 4'd4, 1'b1);
    chk("t5_good_clears_err", 32'(cfg_err), 0);
    pulse_start();
    cfg(8'b0000_0011, 4'd2, 1'b1);
    chk("t5_armed_write_err", 32'(cfg_err), 1);
    send_seq("t5b", 4, 16'b1101, 16'b0001);

    // start and stop together while idle stays idle.
    pulse_stop();
    start = 1'b1;
    stop = 1'b1;
    tick();
    start = 1'b0;
    stop = 1'b0;
    chk("t6_start_stop_idle", 32'(busy), 0);

    // Reset mid-stream restores reset state, including the default config (pattern 0, len 1).
    pulse_start();
    send_seq("t7a", 3, 16'b110, 16'b000);
    rst = 1'b1;
    bit_valid = 1'b1;
    i = 1'b1;
    tick();
    rst = 1'b0;
    bit_valid = 1'b0;
    chk("t7_busy", 32'(busy), 0);
    chk("t7_cnt", 32'(match_cnt), 0);
    chk("t7_evt_valid", 32'(evt_valid), 0);
    chk("t7_out", 32'(out), 0);
    chk("t7_cfg_err", 32'(cfg_err), 0);
    pulse_start();
    send_seq("t7b", 2, 16'b01, 16'b10);
    chk("t7_cnt_default_cfg", 32'(match_cnt), 1);

    // Saturation: five matches on a 2-bit counter give 3; start while armed is ignored.
    pulse_stop();
    pulse_start();
    send_seq("t8", 5, 16'b00000, 16'b11111);
    chk("t8_cnt_wide", 32'(match_cnt), 5);
    chk("t8_cnt_sat", 32'(match_cnt2), 3);
    pulse_start();
    chk("t8_restart_ignored_cnt", 32'(match_cnt), 5);
    chk("t8_restart_ignored_busy", 32'(busy), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
